// File: rtl/aes_pkg.sv
// Shared AES primitives: S-box, GF(2^8) xtime, block width and key-expander state encoding.
package aes_pkg;

   localparam int unsigned Nb = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } kexp_state_t;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry x occupies bits [8*(255-x)+7 -: 8], i.e. a top index of {~x, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b111} -: 8];
   endfunction

   // Multiply by x in GF(2^8) with reduction polynomial 8'h1b.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-box lookups on a 32-bit word.
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] subbed
);

   // byte-wise substitution
   always_comb begin
      subbed = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
   end

endmodule

// File: rtl/aes_key_expander_seq.sv
// Sequential AES key expander: one schedule word per cycle into a register array,
// with combinational round-key readout once the schedule is complete.
module aes_key_expander_seq
   import aes_pkg::*;
#(
   parameter int unsigned Nk = 4,
   parameter int unsigned Nr = Nk + 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [Nk*32-1:0]  key_in,
   input  logic [3:0]        rk_idx,
   output logic              busy,
   output logic              key_ready,
   output logic [127:0]      rk_out
);

   localparam int unsigned NW = Nb * (Nr + 1);
   localparam int unsigned IW = $clog2(NW);
   localparam int unsigned PW = 3;

   kexp_state_t    state, state_next;
   logic [31:0]    w [NW];
   logic [IW-1:0]  i;
   logic [PW-1:0]  phase;
   logic [7:0]     rcon;

   logic           load, step, last;
   logic           busy_next, ready_next;
   logic [31:0]    prev_word, back_word, sw_in, sw_out, temp, new_word;

   logic           rk_valid;
   logic [3:0]     rk_sel;
   logic [IW-1:0]  rk_base;

   aes_sub_word u_sub_word (
      .word   (sw_in),
      .subbed (sw_out)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // next state, load/step enables and next status flags
   always_comb begin
      state_next = state;
      busy_next  = busy;
      ready_next = key_ready;
      load       = 1'b0;
      step       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = EXPAND;
               busy_next  = 1'b1;
               ready_next = 1'b0;
               load       = 1'b1;
            end
         end
         EXPAND: begin
            step = 1'b1;
            if (last) begin
               state_next = IDLE;
               busy_next  = 1'b0;
               ready_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // registered status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         busy      <= 1'b0;
         key_ready <= 1'b0;
      end else begin
         busy      <= busy_next;
         key_ready <= ready_next;
      end
   end

   // word counter, position within the Nk-word group, and round constant
   always_ff @(posedge clk) begin
      if (reset) begin
         i     <= '0;
         phase <= '0;
         rcon  <= 8'h01;
      end else if (load) begin
         i     <= IW'(Nk);
         phase <= '0;
         rcon  <= 8'h01;
      end else if (step) begin
         i     <= i + IW'(1);
         phase <= (phase == PW'(Nk - 1)) ? '0 : phase + PW'(1);
         if (phase == '0) rcon <= xtime(rcon);
      end
   end

   // schedule storage; reset leaves contents untouched, readout is gated by key_ready
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (load) begin
            for (int k = 0; k < Nk; k++) w[k] <= key_in[Nk*32-1-32*k -: 32];
         end else if (step) begin
            w[i] <= new_word;
         end
      end
   end

   // next schedule word; phase tracks i mod Nk so no divider is needed
   always_comb begin
      prev_word = w[i - IW'(1)];
      back_word = w[i - IW'(Nk)];
      last      = (i == IW'(NW - 1));
      sw_in     = (phase == '0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
      if (phase == '0)                     temp = sw_out ^ {rcon, 24'h0};
      else if (Nk == 8 && phase == PW'(4)) temp = sw_out;
      else                                 temp = prev_word;
      new_word  = back_word ^ temp;
   end

   // round-key readout, zero unless a full schedule is held and the index is in range
   always_comb begin
      rk_valid = key_ready && (32'(rk_idx) <= Nr);
      rk_sel   = rk_valid ? rk_idx : 4'd0;
      rk_base  = IW'({rk_sel, 2'b00});
      rk_out   = '0;
      if (rk_valid) begin
         rk_out = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};
      end
   end

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Self-checking bench for aes_key_expander_seq at Nk=4/6/8 against a FIPS-197 reference model.
module tb_aes_key_expander_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic start4, start6, start8;
   logic [127:0] key4;
   logic [191:0] key6;
   logic [255:0] key8;
   logic [3:0] idx4, idx6, idx8;
   logic busy4, busy6, busy8;
   logic ready4, ready6, ready8;
   logic [127:0] rk4, rk6, rk8;

   aes_key_expander_seq #(.Nk(4)) u4 (.clk(clk), .reset(reset), .start(start4), .key_in(key4),
      .rk_idx(idx4), .busy(busy4), .key_ready(ready4), .rk_out(rk4));
   aes_key_expander_seq #(.Nk(6)) u6 (.clk(clk), .reset(reset), .start(start6), .key_in(key6),
      .rk_idx(idx6), .busy(busy6), .key_ready(ready6), .rk_out(rk6));
   aes_key_expander_seq #(.Nk(8)) u8 (.clk(clk), .reset(reset), .start(start8), .key_in(key8),
      .rk_idx(idx8), .busy(busy8), .key_ready(ready8), .rk_out(rk8));

   int checks = 0;
   int failures = 0;

   logic [7:0]   sbox_m [256];
   logic [31:0]  exp_w [60];
   logic [127:0] got_rk [16];

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map
   function automatic logic [7:0] sbox_ref(input logic [7:0] a);
      logic [7:0] b = 8'h00;
      if (a != 8'h00)
         for (int c = 1; c < 256; c++) if (gmul(a, 8'(c)) == 8'h01) b = 8'(c);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw_m(input logic [31:0] t);
      return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_m(input int j);
      logic [7:0] r = 8'h01;
      for (int k = 1; k < j; k++) r = gmul(r, 8'h02);
      return r;
   endfunction

   task automatic model_expand(input int nk, input logic [255:0] key);
      logic [31:0] t;
      int nw;
      nw = 4 * (nk + 7);
      for (int k = 0; k < nk; k++) exp_w[k] = key[nk*32-1-32*k -: 32];
      for (int k = nk; k < nw; k++) begin
         t = exp_w[k-1];
         if (k % nk == 0)                t = subw_m({t[23:0], t[31:24]}) ^ {rcon_m(k / nk), 24'h0};
         else if (nk == 8 && k % 8 == 4) t = subw_m(t);
         exp_w[k] = exp_w[k-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] exp_rk(input int nk, input int r);
      if (r > nk + 6) return 128'h0;
      return {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
   endfunction

   // ---------------- DUT access ----------------
   function automatic logic get_busy(input int nk);
      return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
   endfunction
   function automatic logic get_ready(input int nk);
      return (nk == 4) ? ready4 : (nk == 6) ? ready6 : ready8;
   endfunction
   function automatic logic [127:0] get_rk(input int nk);
      return (nk == 4) ? rk4 : (nk == 6) ? rk6 : rk8;
   endfunction

   task automatic set_start(input int nk, input logic v);
      case (nk) 4: start4 = v; 6: start6 = v; default: start8 = v; endcase
   endtask
   task automatic set_key(input int nk, input logic [255:0] k);
      case (nk) 4: key4 = k[127:0]; 6: key6 = k[191:0]; default: key8 = k; endcase
   endtask
   task automatic set_idx(input int nk, input logic [3:0] v);
      case (nk) 4: idx4 = v; 6: idx6 = v; default: idx8 = v; endcase
   endtask

   function automatic logic [255:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // pulse (or hold) start with key k; returns just after the accepting edge, key_in scrambled
   task automatic do_start(input int nk, input logic [255:0] k, input bit hold);
      @(posedge clk); #1;
      set_key(nk, k);
      set_start(nk, 1'b1);
      @(posedge clk); #1;
      if (!hold) set_start(nk, 1'b0);
      set_key(nk, ~k);
   endtask

   // step edges until key_ready, sweeping rk_idx; reports edges taken and busy/rk anomalies
   task automatic run_until_ready(input int nk, input bit hold, output int cyc,
                                  output int bad_busy, output int bad_rk);
      cyc = 0; bad_busy = 0; bad_rk = 0;
      while (get_ready(nk) !== 1'b1 && cyc < 200) begin
         set_idx(nk, 4'(cyc % 11));
         if (hold) set_key(nk, rand_key());
         @(negedge clk);
         if (get_busy(nk) !== 1'b1) bad_busy++;
         if (get_rk(nk) !== 128'h0) bad_rk++;
         @(posedge clk); #1;
         cyc++;
      end
      set_start(nk, 1'b0);
   endtask

   task automatic read_all(input int nk);
      for (int r = 0; r < 16; r++) begin
         set_idx(nk, 4'(r));
         @(negedge clk);
         got_rk[r] = get_rk(nk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      start4 = 1'b1; start6 = 1'b1; start8 = 1'b1;
      key4 = '0; key6 = '0; key8 = '0;
      idx4 = '0; idx6 = '0; idx8 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
         checks++; if (get_busy(4+2*n) !== 1'b0)
            begin failures++; $display("FAIL reset_busy nk=%0d: got %b expected 0", 4+2*n, get_busy(4+2*n)); end
         checks++; if (get_ready(4+2*n) !== 1'b0)
            begin failures++; $display("FAIL reset_ready nk=%0d: got %b expected 0", 4+2*n, get_ready(4+2*n)); end
         checks++; if (get_rk(4+2*n) !== 128'h0)
            begin failures++; $display("FAIL reset_rk nk=%0d: got %h expected 0", 4+2*n, get_rk(4+2*n)); end
      end
      start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
      reset = 1'b0;
   endtask

   task automatic expand_and_check(input int nk, input logic [255:0] k, input string tag);
      int cyc, bb, br;
      model_expand(nk, k);
      do_start(nk, k, 1'b0);
      run_until_ready(nk, 1'b0, cyc, bb, br);
      checks++; if (cyc != 4*(nk+7) - nk)
         begin failures++; $display("FAIL %s latency nk=%0d: got %0d expected %0d", tag, nk, cyc, 4*(nk+7)-nk); end
      checks++; if (bb != 0)
         begin failures++; $display("FAIL %s busy_low_during_expand nk=%0d: got %0d cycles expected 0", tag, nk, bb); end
      checks++; if (br != 0)
         begin failures++; $display("FAIL %s rk_nonzero_during_busy nk=%0d: got %0d cycles expected 0", tag, nk, br); end
      checks++; if (get_busy(nk) !== 1'b0)
         begin failures++; $display("FAIL %s busy_after_done nk=%0d: got %b expected 0", tag, nk, get_busy(nk)); end
      read_all(nk);
      for (int r = 0; r < 16; r++) begin
         checks++; if (got_rk[r] !== exp_rk(nk, r))
            begin failures++; $display("FAIL %s rk nk=%0d r=%0d: got %h expected %h", tag, nk, r, got_rk[r], exp_rk(nk, r)); end
      end
   endtask

   task automatic test_known_vectors();
      expand_and_check(4, 256'h000102030405060708090a0b0c0d0e0f, "kat");
      expand_and_check(6, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, "kat");
      expand_and_check(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, "kat");
      set_idx(4, 4'd0); set_idx(6, 4'd12); set_idx(8, 4'd14);
      @(negedge clk);
      checks++; if (rk4 !== 128'h000102030405060708090a0b0c0d0e0f)
         begin failures++; $display("FAIL kat_lit nk4 r0: got %h", rk4); end
      checks++; if (rk6 !== 128'ha4970a331a78dc09c418c271e3a41d5d)
         begin failures++; $display("FAIL kat_lit nk6 r12: got %h expected a4970a331a78dc09c418c271e3a41d5d", rk6); end
      checks++; if (rk8 !== 128'h24fc79ccbf0979e9371ac23c6d68de36)
         begin failures++; $display("FAIL kat_lit nk8 r14: got %h expected 24fc79ccbf0979e9371ac23c6d68de36", rk8); end
      set_idx(4, 4'd1);
      @(negedge clk);
      checks++; if (rk4 !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe)
         begin failures++; $display("FAIL kat_lit nk4 r1: got %h expected d6aa74fdd2af72fadaa678f1d6ab76fe", rk4); end
      set_idx(4, 4'd10);
      @(negedge clk);
      checks++; if (rk4 !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
         begin failures++; $display("FAIL kat_lit nk4 r10: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", rk4); end
   endtask

   task automatic test_random_keys();
      for (int t = 0; t < 3; t++) begin
         expand_and_check(4, rand_key(), "rand");
         expand_and_check(6, rand_key(), "rand");
         expand_and_check(8, rand_key(), "rand");
      end
   endtask

   task automatic test_idx_bounds();
      for (int r = 11; r < 16; r++) begin
         set_idx(4, 4'(r));
         @(negedge clk);
         checks++; if (rk4 !== 128'h0)
            begin failures++; $display("FAIL idx_oob nk4 r=%0d: got %h expected 0", r, rk4); end
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] k;
      int cyc, bb, br;
      k = rand_key();
      model_expand(8, k);
      do_start(8, k, 1'b0);
      checks++; if (ready8 !== 1'b0 || busy8 !== 1'b1)
         begin failures++; $display("FAIL restart_flags: got ready=%b busy=%b expected ready=0 busy=1", ready8, busy8); end
      run_until_ready(8, 1'b0, cyc, bb, br);
      checks++; if (cyc != 52)
         begin failures++; $display("FAIL restart_latency: got %0d expected 52", cyc); end
      read_all(8);
      for (int r = 0; r < 15; r++) begin
         checks++; if (got_rk[r] !== exp_rk(8, r))
            begin failures++; $display("FAIL restart_rk r=%0d: got %h expected %h", r, got_rk[r], exp_rk(8, r)); end
      end
   endtask

   task automatic test_start_held();
      logic [255:0] k;
      int cyc, bb, br;
      k = 256'h000102030405060708090a0b0c0d0e0f;
      model_expand(4, k);
      do_start(4, k, 1'b1);
      run_until_ready(4, 1'b1, cyc, bb, br);
      checks++; if (cyc != 40)
         begin failures++; $display("FAIL held_latency: got %0d expected 40", cyc); end
      checks++; if (bb != 0)
         begin failures++; $display("FAIL held_busy_drop: got %0d cycles expected 0", bb); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (ready4 !== 1'b1 || busy4 !== 1'b0)
            begin failures++; $display("FAIL held_ready_stays: got ready=%b busy=%b expected 1/0", ready4, busy4); end
      end
      read_all(4);
      for (int r = 0; r < 11; r++) begin
         checks++; if (got_rk[r] !== exp_rk(4, r))
            begin failures++; $display("FAIL held_rk r=%0d: got %h expected %h", r, got_rk[r], exp_rk(4, r)); end
      end
   endtask

   task automatic test_reset_mid();
      do_start(4, rand_key(), 1'b0);
      set_idx(4, 4'd0);
      repeat (19) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (busy4 !== 1'b0 || ready4 !== 1'b0)
         begin failures++; $display("FAIL midreset_flags: got busy=%b ready=%b expected 0/0", busy4, ready4); end
      checks++; if (rk4 !== 128'h0)
         begin failures++; $display("FAIL midreset_rk: got %h expected 0", rk4); end
      expand_and_check(4, rand_key(), "after_reset");
   endtask

   initial begin
      for (int c = 0; c < 256; c++) sbox_m[c] = sbox_ref(8'(c));
      test_reset();
      test_known_vectors();
      test_random_keys();
      test_idx_bounds();
      test_back_to_back();
      test_start_held();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
